md5_match_scheduler: RTL
========================

# md5_match_scheduler

Controller for the Ducky MD5 search datapath. It takes the byte stream from cmd_parser and keeps a sliding STR_LEN-byte window over it. For every window position it issues one padded 512-bit MD5 message to the fully pipelined MD5 core, then compares each returned digest with the target hash. It reports the byte position of the first matching string and signals run completion after the core pipeline has drained.

## Interface
Parameters:
- STR_LEN, 19: string length in bytes (1..55); message length field = STR_LEN*8 bits.
- LATENCY, 65: MD5 core issue-to-result latency in cycles; the bench model uses it, RTL does not depend on it.

Ports:
- clk_96mhz  in  1  sole clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- proc_start  in  1  one-cycle start pulse; honoured only in IDLE or DONE.
- proc_num_bytes  in  16  bytes in this run; latched on an accepted proc_start.
- proc_data  in  8  stream byte.
- proc_data_valid  in  1  proc_data qualifier, one byte per cycle max, no backpressure.
- proc_target_hash  in  128  target digest; [127:96] vs a, [95:64] vs b, [63:32] vs c, [31:0] vs d; cmd_parser handles byte order.
- proc_done  out  1  level, high in DONE.
- proc_match  out  1  level, a match was found this run.
- proc_byte_pos  out  16  0-based stream offset of the first byte of the first matching string.
- m_out  out  512  padded message to the MD5 core.
- valid_out  out  1  m_out qualifier, one-cycle per message.
- valid_in  in  1  core result qualifier.
- a_in, b_in, c_in, d_in  in  32 each  core digest words.

## Operation
- States: IDLE, FILL, RUN, DRAIN, DONE.
- IDLE/DONE + proc_start: latch num_bytes. Clear the byte count, window, issue count, result count, proc_match, proc_byte_pos and proc_done.
  - Next state is FILL.
  - If num_bytes==0, next state is DONE directly.
- Window shift: each accepted byte shifts into the newest position; the oldest byte drops out.
- Byte count rxd increments on each accepted byte. Bytes arriving in IDLE, DRAIN or DONE are ignored.
- FILL to RUN: on the byte that makes rxd reach STR_LEN. That byte also issues the first message.
- Issue rule: in FILL or RUN, issue on a byte whose arrival gives rxd >= STR_LEN, only while proc_match is 0.
  - issued increments on every issue.
  - After a match, remaining bytes are still counted but no further messages are issued.
- Message packing: m_out[8i+7:8i] = string byte i for i = 0..STR_LEN-1 (byte 0 = oldest).
  - Byte STR_LEN = 8'h80.
  - Bits [511:448] = 64-bit little-endian bit length (STR_LEN*8; 8'h98 at [455:448] for 19).
  - All other bits = 0.
- Result handling: each valid_in in FILL, RUN or DRAIN increments returned; results arrive in issue order.
  - Result k corresponds to stream offset k.
  - If the digest equals the target and proc_match==0: set proc_match=1 and proc_byte_pos=returned (the value before the increment).
  - Later matches are ignored.
- valid_in in IDLE or DONE is ignored.
- Transition to DRAIN: when rxd reaches num_bytes, from FILL or RUN. If num_bytes < STR_LEN there is no issue and DRAIN is entered from FILL.
- DRAIN to DONE: when returned == issued, counting a valid_in in the same cycle.
- proc_start outside IDLE/DONE: ignored, with no effect on any state or count.
- Counters are 16 bits; issued <= num_bytes-STR_LEN+1, so no wrap.

## Timing
- Reset values: state IDLE; proc_done, proc_match, valid_out = 0; proc_byte_pos = 0; m_out = 0; all counters 0.
- Async assert clears immediately; deassert is sampled on the next clk_96mhz edge.
- valid_out/m_out are registered: asserted the cycle after the qualifying proc_data_valid, for one cycle only.
- Back-to-back bytes give back-to-back issues.
- proc_match/proc_byte_pos update the cycle after the matching valid_in.
- proc_done rises the cycle after the DRAIN exit condition. For num_bytes==0 it rises the cycle after proc_start.
- proc_done and proc_match hold until the next accepted proc_start, where they clear on the following edge.
- Simultaneous valid_in and proc_data_valid: both are processed in the same cycle.
- The last byte and the final result can coincide. If that makes returned==issued, go directly to DONE (via a DRAIN pass of zero cycles; proc_done rises the next cycle).
- Reset mid-run aborts immediately. Results still in the core after reset are ignored because state is IDLE.

## Test plan
All scenarios use a bench MD5 model with LATENCY=65.

1. num_bytes=19, "abcdefghijklmnopqrs", target = digest of that string.
   - Exactly one valid_out, 1 cycle after byte 19.
   - m_out bytes 0..18 = string, [159:152]=8'h80, [455:448]=8'h98.
   - proc_match=1, proc_byte_pos=0, proc_done 1 cycle after the result.
2. num_bytes=100 random, target = digest of offset 37.
   - proc_byte_pos=37.
   - No valid_out after the match is flagged.
   - proc_done after the outstanding results return.
3. num_bytes=10: no valid_out; proc_done the cycle after byte 10; proc_match=0.
4. num_bytes=0: proc_done the cycle after proc_start; no valid_out.
5. Data containing target strings at offsets 5 and 20, bytes with gaps of 0–3 idle cycles: proc_byte_pos=5; issues track bytes one-for-one.
6. Disruption cases:
   - proc_start pulsed mid-RUN: no effect on the run.
   - reset_n asserted mid-RUN: all outputs 0 immediately.
   - A fresh run of case 1 after release: passes despite stale core results.

Source files
------------

// File: rtl/md5_match_scheduler.sv
// md5_match_scheduler: slides a STR_LEN-byte window over the cmd_parser byte
// stream, issues one padded MD5 block per window position to a fully pipelined
// MD5 core, and compares the returned digests against the target hash. Reports
// the offset of the first matching string and completes once the core drains.
module md5_match_scheduler #(
  parameter int unsigned STR_LEN = 19,
  parameter int unsigned LATENCY = 65
) (
  input  logic         clk_96mhz,
  input  logic         reset_n,
  input  logic         proc_start,
  input  logic [15:0]  proc_num_bytes,
  input  logic [7:0]   proc_data,
  input  logic         proc_data_valid,
  input  logic [127:0] proc_target_hash,
  output logic         proc_done,
  output logic         proc_match,
  output logic [15:0]  proc_byte_pos,
  output logic [511:0] m_out,
  output logic         valid_out,
  input  logic         valid_in,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in
);

  // Counter width is fixed at 16 bits; LATENCY is carried for interface
  // compatibility only, since results are tracked by count, not by timing.
  localparam int unsigned CntW = 16 + 0 * LATENCY;
  localparam int unsigned WinW = 8 * STR_LEN;

  localparam logic [CntW-1:0] StrLenC = CntW'(STR_LEN);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFill  = 3'd1;
  localparam logic [2:0] StRun   = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] num_q, num_d;
  logic [CntW-1:0] rxd_q, rxd_d;
  logic [CntW-1:0] issued_q, issued_d;
  logic [CntW-1:0] returned_q, returned_d;
  logic [WinW-1:0] win_q, win_d;
  logic            match_q, match_d;
  logic [CntW-1:0] pos_q, pos_d;
  logic [511:0]    m_q, m_d;
  logic            vout_q, vout_d;

  logic            active;
  logic            accept;
  logic            res_ok;
  logic            hit;
  logic            issue;
  logic [CntW-1:0] rxd_inc;
  logic [CntW-1:0] iss_inc;
  logic [CntW-1:0] ret_inc;
  logic [511:0]    pad;

  // Fixed MD5 padding for a single-block message: 0x80 marker plus bit length.
  always_comb begin
    pad                    = '0;
    pad[8*STR_LEN +: 8]    = 8'h80;
    pad[511:448]           = 64'(STR_LEN * 8);
  end

  // Next-state logic: window shift, issue decision, result compare, FSM.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    rxd_d      = rxd_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    win_d      = win_q;
    match_d    = match_q;
    pos_d      = pos_q;
    m_d        = m_q;
    vout_d     = 1'b0;

    active  = (state_q == StFill) || (state_q == StRun);
    accept  = proc_data_valid && active;
    res_ok  = valid_in && (active || (state_q == StDrain));
    hit     = ({a_in, b_in, c_in, d_in} == proc_target_hash);
    rxd_inc = rxd_q + CntW'(accept);
    issue   = accept && (rxd_inc >= StrLenC) && !match_q;
    iss_inc = issued_q + CntW'(issue);
    ret_inc = returned_q + CntW'(res_ok);

    // Newest byte enters at the top so byte 0 of the window is the oldest.
    if (accept) begin
      win_d = (win_q >> 8) | (WinW'(proc_data) << (WinW - 8));
    end

    if (issue) begin
      m_d    = pad | 512'(win_d);
      vout_d = 1'b1;
    end

    // Only the first matching digest of a run is recorded.
    if (res_ok && hit && !match_q) begin
      match_d = 1'b1;
      pos_d   = returned_q;
    end

    case (state_q)
      StIdle, StDone: begin
        if (proc_start) begin
          num_d      = proc_num_bytes;
          rxd_d      = '0;
          issued_d   = '0;
          returned_d = '0;
          win_d      = '0;
          match_d    = 1'b0;
          pos_d      = '0;
          state_d    = (proc_num_bytes == '0) ? StDone : StFill;
        end
      end
      StFill, StRun: begin
        rxd_d      = rxd_inc;
        issued_d   = iss_inc;
        returned_d = ret_inc;
        if (accept && (rxd_inc == num_q)) begin
          // Skip DRAIN when nothing is left in flight.
          state_d = (ret_inc == iss_inc) ? StDone : StDrain;
        end else if ((state_q == StFill) && accept && (rxd_inc == StrLenC)) begin
          state_d = StRun;
        end
      end
      StDrain: begin
        returned_d = ret_inc;
        if (ret_inc == issued_q) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_96mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      num_q      <= '0;
      rxd_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      win_q      <= '0;
      match_q    <= 1'b0;
      pos_q      <= '0;
      m_q        <= '0;
      vout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      rxd_q      <= rxd_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      win_q      <= win_d;
      match_q    <= match_d;
      pos_q      <= pos_d;
      m_q        <= m_d;
      vout_q     <= vout_d;
    end
  end

  assign proc_done     = (state_q == StDone);
  assign proc_match    = match_q;
  assign proc_byte_pos = pos_q;
  assign m_out         = m_q;
  assign valid_out     = vout_q;

endmodule
